// File: rtl/hazard_controller.sv
// Purpose: pipeline hazard/sequencing control - E-stage forwarding selects, load-use and mul/div stalls, branch flushes, perf counters.
// Latency: forwarding, stall and flush outputs are combinational from the current stage fields; counters and mul/div state update on the next edge.
// Backpressure: a load-use hazard holds F/D for one cycle; a mul/div op holds F/D/E for MD_LATENCY-1 cycles; a taken branch never stalls.
module hazard_controller #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             ResultSrcE0,
   input  logic             PCSrcE,
   input  logic             MulDivE,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             FlushD,
   output logic             FlushE,
   output logic             MdBusy,
   output logic [CNT_W-1:0] StallCount,
   output logic [CNT_W-1:0] FlushCount
);

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   // A single-cycle op needs no sequencing; a two-cycle op skips BUSY entirely.
   localparam bit         MD_ENABLE = (MD_LATENCY > 1);
   localparam bit         MD_SHORT  = (MD_LATENCY == 2);
   // BUSY is entered after the start cycle and left one cycle before DONE,
   // so the counter covers the remaining MD_LATENCY-3 stall cycles.
   localparam int         BUSY_LOAD = (MD_LATENCY > 3) ? (MD_LATENCY - 3) : 0;
   localparam logic [3:0] CNT_LOAD  = 4'(BUSY_LOAD);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   md_state_t  state;
   md_state_t  state_next;
   logic [3:0] cnt;
   logic [3:0] cnt_next;
   logic       md_start;
   logic       md_stall;
   logic       lw_stall;

   // Select source for one E operand; the younger M result beats W, and x0 is never forwarded.
   function automatic logic [1:0] fwd_select(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       wr_m,
      input logic [4:0] rd_w,
      input logic       wr_w
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (wr_m && (rd_m == rs) && (rs != 5'd0)) begin
         sel = 2'b10;
      end else if (wr_w && (rd_w == rs) && (rs != 5'd0)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Forwarding muxes stay live through reset since they carry no state.
   always_comb begin
      ForwardAE = fwd_select(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_select(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
   end

   // Load in E whose destination is a source of the instruction in D.
   always_comb begin
      lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
   end

   // Mul/div sequencer next-state; a branch resolving in the same cycle suppresses the start.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      md_start   = 1'b0;
      md_stall   = 1'b0;
      case (state)
         MD_IDLE: begin
            md_start = MD_ENABLE && MulDivE && !PCSrcE;
            if (md_start) begin
               if (MD_SHORT) begin
                  state_next = MD_DONE;
               end else begin
                  state_next = MD_BUSY;
                  cnt_next   = CNT_LOAD;
               end
            end
         end
         MD_BUSY: begin
            if (cnt == 4'd0) begin
               state_next = MD_DONE;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         MD_DONE: begin
            // The finishing op is still visible in E here; ignore MulDivE so it is not restarted.
            state_next = MD_IDLE;
         end
         default: begin
            state_next = MD_IDLE;
            cnt_next   = 4'd0;
         end
      endcase
      md_stall = md_start || (state == MD_BUSY);
   end

   // Sequencer state register; reset aborts any op in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= MD_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Pipeline controls, all quiet while reset is held.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      MdBusy = 1'b0;
      if (!reset) begin
         StallF = lw_stall || md_stall;
         StallD = lw_stall || md_stall;
         StallE = md_stall;
         FlushD = PCSrcE;
         FlushE = lw_stall || PCSrcE;
         MdBusy = md_stall;
      end
   end

   // Saturating event counters for stall and flush cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         StallCount <= '0;
         FlushCount <= '0;
      end else begin
         if (StallF && (StallCount != CNT_MAX)) begin
            StallCount <= StallCount + CNT_ONE;
         end
         if ((FlushD || FlushE) && (FlushCount != CNT_MAX)) begin
            FlushCount <= FlushCount + CNT_ONE;
         end
      end
   end

endmodule
